samp_play_ctl: RTL and testbench
================================

// Module: samp_play_ctl
// PURPOSE
//  Playback sequencer and sample-RAM arbiter for the wave generator. Paces reads of the
//  1024x16 sample RAM from NSAMP/PRESCALE/SPEED and hands each sample to the DAC SPI
//  shifter over a valid/ready handshake. Shares the RAM's single port with the command
//  parser (writes/reads). Sits between cmd_parse, the sample RAM and the DAC SPI block.
// PARAMETERS
//  AW        10     sample RAM address width (depth 2**AW)
//  DW        16     sample width
//  PRE_MIN   32     minimum effective prescale
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      reset, asynchronous, active-low
//  play_en      in   1      level: 1 = playback running
//  nsamp        in   AW+1   samples per waveform, 1..1024
//  prescale     in   16     clocks per tick
//  speed        in   16     ticks per sample
//  cmd_req      in   1      parser RAM access request, held until cmd_gnt
//  cmd_we       in   1      1 = write, 0 = read (valid with cmd_req)
//  cmd_addr     in   AW     parser address
//  cmd_wdata    in   DW     parser write data
//  cmd_gnt      out  1      1-cycle pulse: parser access issued this cycle
//  cmd_rvalid   out  1      1-cycle pulse: cmd_rdata valid (read only)
//  cmd_rdata    out  DW     parser read data
//  ram_en       out  1      RAM port enable
//  ram_we       out  1      RAM write enable
//  ram_addr     out  AW     RAM address
//  ram_wdata    out  DW     RAM write data
//  ram_rdata    in   DW     RAM read data, 1-cycle latency after ram_en
//  samp_val     out  1      sample valid to DAC SPI
//  samp         out  DW     sample data
//  samp_rdy     in   1      DAC SPI accepts when samp_val & samp_rdy
//  underrun     out  1      1-cycle pulse: new sample due while previous not accepted
//  play_addr    out  AW     current playback address (debug)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters and play_addr 0; arb last-grant = PLAY.
//  Clamping: eff_pre = max(prescale,PRE_MIN); eff_spd = max(speed,1);
//   eff_ns = nsamp==0 ? 1 : min(nsamp,1024). Sample period = eff_pre*eff_spd clocks.
//  Pacing: pre_cnt counts 0..eff_pre-1, tick when ==eff_pre-1 then wraps to 0; spd_cnt
//   counts ticks 0..eff_spd-1; sample due on tick with spd_cnt==eff_spd-1.
//   prescale/speed change takes effect at next counter compare (no restart).
//   If a counter is above a newly lowered limit, it wraps to 0 on next compare (>=).
//  FSM: IDLE -play_en-> FETCH (first sample immediately, addr 0, counters cleared).
//   FETCH: raise play_req; on play grant -> RDWAIT. RDWAIT: next cycle load ram_rdata
//   into samp, samp_val=1 -> WAIT. WAIT: on sample due -> FETCH with addr+1, or
//   addr 0 when addr==eff_ns-1 (wrap; nsamp resampled at wrap only).
//   play_en=0 in any state -> IDLE next cycle; samp_val cleared, addr/counters zeroed;
//   an in-flight RAM read is discarded.
//  Handshake: samp_val held with samp stable until samp_val&samp_rdy; then samp_val=0.
//   Sample due with samp_val still 1: underrun pulses, old sample is replaced by new
//   fetch (samp_val stays 1), address still advances.
//  Arbitration (one RAM access/cycle): single requester wins. On conflict grant the one
//   not granted last (round-robin), so neither waits >1 cycle. Granted cmd: ram_en=1,
//   ram_we=cmd_we, cmd_gnt pulse; reads give cmd_rvalid one cycle later.
//   Play grant: ram_en=1, ram_we=0, ram_addr=play_addr.
//  Writes to the address being played are allowed; playback sees new data on next read.
// STRUCTURE
//  Package wave_gen_pkg: AW, DW, PRE_MIN, NSAMP_MAX, FSM state encodings.
//  Sub-module samp_rate_gen: pre_cnt/spd_cnt pacing, outputs sample-due pulse.
//  Arbiter, FSM and handshake register stay in samp_play_ctl.
// TESTING
//  1 nsamp=4,prescale=32,speed=1, RAM[0..3]=A,B,C,D, samp_rdy=1 -> A,B,C,D,A every 32 clk.
//  2 prescale=5,speed=0,nsamp=0 -> clamped: period 32 clk, only addr 0 replayed.
//  3 samp_rdy=0 for 3 sample periods -> underrun pulses 3x, samp always newest value.
//  4 cmd_req held every cycle during playback -> grants alternate, no sample late >1 clk,
//    cmd read of addr 7 returns RAM[7] on cmd_rvalid one clk after cmd_gnt.
//  5 play_en dropped in RDWAIT -> next clk IDLE, samp_val=0, no sample emitted; re-enable
//    restarts at addr 0.
//  6 rst_n asserted mid-WAIT (async) -> outputs 0 immediately, FSM IDLE after release.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared sizes and state encodings for the wave generator playback path.
package wave_gen_pkg;
  localparam int AW        = 10;
  localparam int DW        = 16;
  localparam int PRE_MIN   = 32;
  localparam int NSAMP_MAX = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_WAIT   = 2'd3
  } play_st_e;

  typedef enum logic {
    ARB_PLAY = 1'b0,
    ARB_CMD  = 1'b1
  } arb_src_e;
endpackage

// File: rtl/samp_rate_gen.sv
// Sample pacing: prescale down to ticks, ticks down to one sample-due pulse per period.
module samp_rate_gen
  import wave_gen_pkg::*;
#(
  parameter int PRE_MIN_P = wave_gen_pkg::PRE_MIN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [15:0] prescale,
  input  logic [15:0] speed,
  output logic        due
);
  logic [15:0] pre_q, pre_d, spd_q, spd_d;
  logic [15:0] eff_pre, eff_spd;
  logic        pre_tc, spd_tc;

  // >= compares let a counter sitting above a freshly lowered limit wrap cleanly.
  always_comb begin
    eff_pre = (prescale < 16'(PRE_MIN_P)) ? 16'(PRE_MIN_P) : prescale;
    eff_spd = (speed == 16'd0) ? 16'd1 : speed;
    pre_tc  = pre_q >= (eff_pre - 16'd1);
    spd_tc  = spd_q >= (eff_spd - 16'd1);
    due     = !clr && pre_tc && spd_tc;
    pre_d   = pre_q;
    spd_d   = spd_q;
    if (clr) begin
      pre_d = '0;
      spd_d = '0;
    end else if (pre_tc) begin
      pre_d = '0;
      spd_d = spd_tc ? 16'd0 : spd_q + 16'd1;
    end else begin
      pre_d = pre_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      spd_q <= '0;
    end else begin
      pre_q <= pre_d;
      spd_q <= spd_d;
    end
  end
endmodule

// File: rtl/samp_play_ctl.sv
// Playback sequencer plus round-robin arbiter sharing the sample RAM port with cmd_parse.
module samp_play_ctl
  import wave_gen_pkg::*;
#(
  parameter int AW      = wave_gen_pkg::AW,
  parameter int DW      = wave_gen_pkg::DW,
  parameter int PRE_MIN = wave_gen_pkg::PRE_MIN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          play_en,
  input  logic [AW:0]   nsamp,
  input  logic [15:0]   prescale,
  input  logic [15:0]   speed,
  input  logic          cmd_req,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          cmd_gnt,
  output logic          cmd_rvalid,
  output logic [DW-1:0] cmd_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          samp_val,
  output logic [DW-1:0] samp,
  input  logic          samp_rdy,
  output logic          underrun,
  output logic [AW-1:0] play_addr
);
  play_st_e      st_q, st_d;
  arb_src_e      last_q, last_d;
  logic [AW-1:0] addr_q, addr_d, ns_last_q, ns_last_d, ns_last;
  logic [AW:0]   eff_ns;
  logic [DW-1:0] samp_q, samp_d, ram_wdata_q, ram_wdata_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          samp_val_q, samp_val_d, underrun_q, underrun_d;
  logic          ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic          cmd_gnt_q, cmd_gnt_d, play_gnt_q, play_gnt_d, cmd_rvalid_q, cmd_rvalid_d;
  logic          play_req, cmd_pend, gnt_cmd, gnt_play, due, rate_clr;

  assign rate_clr = !play_en || (st_q == ST_IDLE);

  samp_rate_gen #(.PRE_MIN_P(PRE_MIN)) u_rate (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (rate_clr),
    .prescale (prescale),
    .speed    (speed),
    .due      (due)
  );

  // Grants are registered, so a requester is masked in the cycle its grant is visible.
  always_comb begin
    eff_ns = (nsamp == '0) ? (AW+1)'(1) :
             (nsamp > (AW+1)'(NSAMP_MAX)) ? (AW+1)'(NSAMP_MAX) : nsamp;
    ns_last      = AW'(eff_ns - (AW+1)'(1));
    play_req     = (st_q == ST_FETCH) && play_en && !play_gnt_q;
    cmd_pend     = cmd_req && !cmd_gnt_q;
    gnt_cmd      = cmd_pend && (!play_req || (last_q == ARB_PLAY));
    gnt_play     = play_req && !gnt_cmd;
    ram_en_d     = gnt_cmd || gnt_play;
    ram_we_d     = gnt_cmd && cmd_we;
    ram_addr_d   = gnt_cmd ? cmd_addr : addr_q;
    ram_wdata_d  = gnt_cmd ? cmd_wdata : '0;
    cmd_gnt_d    = gnt_cmd;
    play_gnt_d   = gnt_play;
    cmd_rvalid_d = cmd_gnt_q && !ram_we_q;
    last_d       = gnt_cmd ? ARB_CMD : (gnt_play ? ARB_PLAY : last_q);
  end

  always_comb begin
    st_d       = st_q;
    addr_d     = addr_q;
    ns_last_d  = ns_last_q;
    samp_d     = samp_q;
    samp_val_d = samp_val_q;
    underrun_d = 1'b0;
    if (samp_val_q && samp_rdy) samp_val_d = 1'b0;
    if (!play_en) begin
      st_d       = ST_IDLE;
      addr_d     = '0;
      samp_val_d = 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_d      = ST_FETCH;
          addr_d    = '0;
          ns_last_d = ns_last;
        end
        ST_FETCH: if (play_gnt_q) st_d = ST_RDWAIT;
        ST_RDWAIT: begin
          samp_d     = ram_rdata;
          samp_val_d = 1'b1;
          st_d       = ST_WAIT;
        end
        ST_WAIT: if (due) begin
          st_d       = ST_FETCH;
          underrun_d = samp_val_q && !samp_rdy;
          if (addr_q == ns_last_q) begin
            addr_d    = '0;
            ns_last_d = ns_last;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      last_q       <= ARB_PLAY;
      addr_q       <= '0;
      ns_last_q    <= '0;
      samp_q       <= '0;
      samp_val_q   <= 1'b0;
      underrun_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cmd_gnt_q    <= 1'b0;
      play_gnt_q   <= 1'b0;
      cmd_rvalid_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      ns_last_q    <= ns_last_d;
      samp_q       <= samp_d;
      samp_val_q   <= samp_val_d;
      underrun_q   <= underrun_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cmd_gnt_q    <= cmd_gnt_d;
      play_gnt_q   <= play_gnt_d;
      cmd_rvalid_q <= cmd_rvalid_d;
    end
  end

  assign cmd_gnt    = cmd_gnt_q;
  assign cmd_rvalid = cmd_rvalid_q;
  assign cmd_rdata  = cmd_rvalid_q ? ram_rdata : '0;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign samp_val   = samp_val_q;
  assign samp       = samp_q;
  assign underrun   = underrun_q;
  assign play_addr  = addr_q;
endmodule

// File: tb/tb_samp_play_ctl.sv
// Bench for samp_play_ctl: behavioural sample RAM, sample/read scoreboards, directed scenarios.
module tb_samp_play_ctl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        play_en, cmd_req, cmd_we, samp_rdy;
  logic [10:0] nsamp;
  logic [15:0] prescale, speed;
  logic [9:0]  cmd_addr, ram_addr, play_addr;
  logic [15:0] cmd_wdata, cmd_rdata, ram_wdata, ram_rdata, samp;
  logic        cmd_gnt, cmd_rvalid, ram_en, ram_we, samp_val, underrun;

  samp_play_ctl dut (
    .clk(clk), .rst_n(rst_n), .play_en(play_en), .nsamp(nsamp), .prescale(prescale),
    .speed(speed), .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_gnt(cmd_gnt), .cmd_rvalid(cmd_rvalid), .cmd_rdata(cmd_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .samp_val(samp_val), .samp(samp), .samp_rdy(samp_rdy),
    .underrun(underrun), .play_addr(play_addr)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  localparam logic [15:0] VA = 16'hA0A0, VB = 16'hB1B1, VC = 16'hC2C2, VD = 16'hD3D3;
  logic [15:0] shadow [1024];
  logic [15:0] samp_exp_q[$];
  logic [15:0] cmd_exp_q[$];
  int cyc = 0, last_acc = 0, gap_v = 0, gap_mode = 0, under_cnt = 0, rd_cnt = 0;
  bit have_last = 0, prev_gnt_rd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (samp_val && samp_rdy) begin
        if (samp_exp_q.size() == 0) begin
          check("samp_extra", 32'(samp_val && samp_rdy), 32'd0);
        end else begin
          check("samp", 32'(samp), 32'(samp_exp_q.pop_front()));
          gap_v = cyc - last_acc;
          if (have_last && gap_mode == 1) check("samp_gap", gap_v, 32);
          if (have_last && gap_mode == 2) check("samp_gap_tol", 32'(gap_v >= 31 && gap_v <= 33), 32'd1);
          last_acc  = cyc;
          have_last = 1;
        end
      end
      if (underrun) under_cnt++;
      if (prev_gnt_rd || cmd_rvalid) check("rvalid_lat", 32'(cmd_rvalid), 32'(prev_gnt_rd));
      if (cmd_rvalid) begin
        rd_cnt++;
        if (cmd_exp_q.size() == 0) check("rdata_extra", 32'(cmd_rvalid), 32'd0);
        else check("cmd_rdata", 32'(cmd_rdata), 32'(cmd_exp_q.pop_front()));
      end
      prev_gnt_rd = cmd_gnt && !cmd_we;
      if (cmd_gnt && !cmd_we) cmd_exp_q.push_back(shadow[cmd_addr]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd_access(input bit we, input logic [9:0] a, input logic [15:0] d);
    int n;
    bit got;
    n = 0;
    got = 0;
    cmd_we = we;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_req = 1'b1;
    if (we) shadow[a] = d;
    while (!got && n < 20) begin
      @(negedge clk);
      got = cmd_gnt;
      n++;
    end
    check("cmd_gnt_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1 cmd_req = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (samp_exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, samp_exp_q.size(), 0);
  endtask

  task automatic wait_fetch(input string tag);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = ram_en && !ram_we;
      n++;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; play_en = 0; cmd_req = 0; cmd_we = 0; samp_rdy = 0;
    nsamp = 11'd4; prescale = 16'd32; speed = 16'd1; cmd_addr = '0; cmd_wdata = '0;
    #23;
    check("rst_samp_val", 32'(samp_val), 0);
    check("rst_samp", 32'(samp), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_cmd_gnt", 32'(cmd_gnt), 0);
    check("rst_play_addr", 32'(play_addr), 0);
    check("rst_underrun", 32'(underrun), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // RAM image loaded through the parser port, then read back.
    cmd_access(1, 10'd0, VA);
    cmd_access(1, 10'd1, VB);
    cmd_access(1, 10'd2, VC);
    cmd_access(1, 10'd3, VD);
    cmd_access(1, 10'd7, 16'h7777);
    cmd_access(0, 10'd2, 16'h0);
    tick(3);
    check("rd_back_cnt", rd_cnt, 1);

    // 1: four-sample waveform at the minimum period.
    samp_rdy = 1; gap_mode = 1; have_last = 0;
    samp_exp_q = '{VA, VB, VC, VD, VA};
    play_en = 1;
    drain("t1_drain", 5 * 32 + 20);
    play_en = 0;
    tick(3);
    check("t1_stop_addr", 32'(play_addr), 0);

    // 2: clamped prescale/speed/nsamp replays addr 0 every 32 clocks.
    prescale = 16'd5; speed = 16'd0; nsamp = 11'd0; have_last = 0;
    samp_exp_q = '{VA, VA, VA};
    play_en = 1;
    drain("t2_drain", 3 * 32 + 20);
    check("t2_addr", 32'(play_addr), 0);
    play_en = 0;
    tick(3);

    // 3: DAC stalled for three periods.
    prescale = 16'd32; speed = 16'd1; nsamp = 11'd4;
    samp_rdy = 0; gap_mode = 0; under_cnt = 0;
    play_en = 1;
    tick(110);
    check("t3_underruns", under_cnt, 3);
    check("t3_samp_newest", 32'(samp), 32'(VD));
    check("t3_samp_val", 32'(samp_val), 1);
    check("t3_addr", 32'(play_addr), 3);
    samp_exp_q.push_back(VD);
    samp_rdy = 1;
    tick(1);
    play_en = 0;
    check("t3_accept", samp_exp_q.size(), 0);
    tick(3);

    // 4: parser hammers reads of addr 7 during playback.
    gap_mode = 2; have_last = 0; rd_cnt = 0;
    samp_exp_q = '{VA, VB, VC, VD};
    cmd_we = 0; cmd_addr = 10'd7; cmd_req = 1;
    play_en = 1;
    drain("t4_drain", 4 * 33 + 30);
    play_en = 0;
    cmd_req = 0;
    tick(4);
    check("t4_rd_cnt", 32'(rd_cnt >= 40), 1);
    check("t4_cmd_q_empty", cmd_exp_q.size(), 0);

    // 5: play_en dropped while the first read is in flight.
    gap_mode = 0;
    play_en = 1;
    wait_fetch("t5_fetch_seen");
    @(posedge clk);
    #1 play_en = 0;
    @(negedge clk);
    check("t5_samp_val", 32'(samp_val), 0);
    check("t5_addr", 32'(play_addr), 0);
    tick(40);
    have_last = 0; gap_mode = 1;
    samp_exp_q = '{VA, VB};
    play_en = 1;
    drain("t5_restart", 2 * 32 + 20);
    check("t5_restart_addr", 32'(play_addr), 1);
    play_en = 0;
    tick(3);

    // 6: async reset while waiting on the DAC.
    gap_mode = 0; samp_rdy = 0;
    play_en = 1;
    tick(10);
    check("t6_pre_val", 32'(samp_val), 1);
    #2 rst_n = 0;
    #1;
    check("t6_rst_val", 32'(samp_val), 0);
    check("t6_rst_samp", 32'(samp), 0);
    check("t6_rst_addr", 32'(play_addr), 0);
    play_en = 0;
    tick(1);
    rst_n = 1;
    tick(5);
    check("t6_idle_ram_en", 32'(ram_en), 0);
    check("t6_idle_val", 32'(samp_val), 0);
    samp_rdy = 1; have_last = 0;
    samp_exp_q = '{VA};
    play_en = 1;
    drain("t6_restart", 20);
    play_en = 0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
